// File: rtl/tone_pkg.sv
// Shared types and default constants for the tone period meter.
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LOCK  = 2'd2
    } state_t;

    localparam int unsigned CNT_W_DEF    = 20;
    localparam int unsigned TIMEOUT_DEF  = 1_000_000;
    localparam int unsigned STABLE_N_DEF = 4;
    localparam int unsigned TOL_DEF      = 8;

endpackage

// File: rtl/sig_sync_edge.sv
// Three-flop synchroniser for an asynchronous level, with rising-edge detect
// taken from the two settled stages.
module sig_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // NOTE: every flop here is clocked state, so all use non-blocking
    // assignments; the chain is cleared so no stale edge survives a reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign rise = r_s2 & ~r_s3;

endmodule

// File: rtl/tone_meter.sv
// Measures the period of an external square wave in clk cycles, declares lock
// once consecutive periods agree within TOL, and flags loss after TIMEOUT.
module tone_meter
    import tone_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
    parameter int unsigned STABLE_N = STABLE_N_DEF,
    parameter int unsigned TOL      = TOL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             tone_present,
    output logic             lost
);

    localparam int unsigned        MATCH_W    = $clog2(STABLE_N + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   TOL_C      = CNT_W'(TOL);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(STABLE_N);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

    logic               w_rise;
    logic [CNT_W-1:0]   w_meas;
    logic [CNT_W-1:0]   w_diff;
    logic               w_in_tol;
    logic               w_timeout;
    logic [MATCH_W-1:0] w_match_next;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_prev;
    logic [MATCH_W-1:0] r_match;

    sig_sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (w_rise)
    );

    // Period ending on this cycle's edge, and its distance from the last one.
    assign w_meas = r_cnt + CNT_W'(1);
    assign w_diff = (w_meas >= r_prev) ? (w_meas - r_prev) : (r_prev - w_meas);

    // An empty run has no reference period, so its first member never matches.
    assign w_in_tol = (r_match != '0) && (w_diff <= TOL_C);

    assign w_match_next = !w_in_tol               ? MATCH_ONE  :
                          (r_match == MATCH_FULL) ? MATCH_FULL :
                                                    r_match + MATCH_ONE;

    // An edge on the last counted cycle wins over the timeout.
    assign w_timeout = (r_cnt == CNT_LAST) && !w_rise;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_prev       <= '0;
            r_match      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            tone_present <= 1'b0;
            lost         <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here, so any branch that does
            // not raise them yields a single-cycle pulse.
            period_valid <= 1'b0;
            lost         <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_rise) begin
                        r_state <= ARMED;
                        r_match <= '0;
                    end
                end

                ARMED: begin
                    if (w_rise) begin
                        r_cnt   <= '0;
                        r_prev  <= w_meas;
                        r_match <= w_match_next;
                        if (w_match_next == MATCH_FULL) begin
                            r_state      <= LOCK;
                            period       <= w_meas;
                            period_valid <= 1'b1;
                            tone_present <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_match <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                LOCK: begin
                    if (w_rise) begin
                        r_cnt   <= '0;
                        r_prev  <= w_meas;
                        r_match <= w_match_next;
                        if (w_in_tol) begin
                            period       <= w_meas;
                            period_valid <= 1'b1;
                        end else begin
                            r_state      <= ARMED;
                            tone_present <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state      <= IDLE;
                        r_cnt        <= '0;
                        r_match      <= '0;
                        tone_present <= 1'b0;
                        lost         <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state      <= IDLE;
                    r_cnt        <= '0;
                    r_match      <= '0;
                    tone_present <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_meter.sv
// Bench for tone_meter: scenario table, hand-written corner sequences and
// random tones, all cross-checked every cycle against a timestamp-based model.
module tb_tone_meter;
    import tone_pkg::*;

    localparam int unsigned CNT_W    = CNT_W_DEF;
    localparam int unsigned TB_TMO   = 1000;
    localparam int unsigned STABLE_N = STABLE_N_DEF;
    localparam int unsigned TOL      = TOL_DEF;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             tone_present;
    logic             lost;

    tone_meter #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TB_TMO),
        .STABLE_N (STABLE_N),
        .TOL      (TOL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .tone_present (tone_present),
        .lost         (lost)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: works on edge timestamps. An input rise first sampled
    // at edge k is acted on at edge k+2; periods are timestamp differences.
    int  edge_k = 0;
    bit  m_last_samp;
    int  m_pend[$];
    bit  m_active;
    bit  m_locked;
    int  m_run;
    int  m_prev;
    int  m_last_e;
    int  m_period;
    bit  m_pv;
    bit  m_lost;

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_step();
        bit rise_now;
        bit ok;
        int meas;
        edge_k++;
        m_pv   = 1'b0;
        m_lost = 1'b0;
        if (rst !== 1'b1) begin
            m_last_samp = 1'b0;
            m_pend.delete();
            m_active = 1'b0;
            m_locked = 1'b0;
            m_run    = 0;
            m_prev   = 0;
            m_period = 0;
            return;
        end
        rise_now = 1'b0;
        if (m_pend.size() > 0 && m_pend[0] == edge_k) begin
            rise_now = 1'b1;
            void'(m_pend.pop_front());
        end
        if (sig_in === 1'b1 && !m_last_samp) m_pend.push_back(edge_k + 2);
        m_last_samp = (sig_in === 1'b1);

        if (!m_active) begin
            if (rise_now) begin
                m_active = 1'b1;
                m_run    = 0;
                m_last_e = edge_k;
            end
        end else if (rise_now) begin
            meas     = edge_k - m_last_e;
            m_last_e = edge_k;
            ok       = (m_run > 0) && (absdiff(meas, m_prev) <= int'(TOL));
            m_prev   = meas;
            if (m_locked) begin
                if (ok) begin
                    m_period = meas;
                    m_pv     = 1'b1;
                end else begin
                    m_locked = 1'b0;
                    m_run    = 1;
                end
            end else begin
                m_run = ok ? ((m_run < int'(STABLE_N)) ? m_run + 1 : int'(STABLE_N)) : 1;
                if (m_run == int'(STABLE_N)) begin
                    m_locked = 1'b1;
                    m_period = meas;
                    m_pv     = 1'b1;
                end
            end
        end else if (edge_k - m_last_e == int'(TB_TMO)) begin
            m_lost   = m_locked;
            m_locked = 1'b0;
            m_active = 1'b0;
            m_run    = 0;
        end
    endtask

    bit mon_en       = 1'b0;
    bit glitch_phase = 1'b0;
    int pv_count     = 0;
    int lost_count   = 0;
    int glitch_bad   = 0;
    int last_pv_edge = 0;
    int lost_edge    = 0;

    always @(posedge clk) begin
        model_step();
        #1;
        if (mon_en)
            check($sformatf("cycle@%0d", edge_k),
                  64'({period, period_valid, tone_present, lost}),
                  64'({m_period[CNT_W-1:0], m_pv, m_locked, m_lost}));
        if (period_valid === 1'b1) begin
            pv_count++;
            last_pv_edge = edge_k;
            if (glitch_phase && period != CNT_W'(100)) glitch_bad++;
        end
        if (lost === 1'b1) begin
            lost_count++;
            lost_edge = edge_k;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic tone_period(input int per, input int hi);
        sig_in = 1'b1;
        repeat (hi) @(negedge clk);
        sig_in = 1'b0;
        repeat (per - hi) @(negedge clk);
    endtask

    task automatic glitch_period(input int per);
        sig_in = 1'b1;
        repeat (per / 2) @(negedge clk);
        sig_in = 1'b0;
        repeat (per / 4) @(negedge clk);
        sig_in = 1'b1;
        @(negedge clk);
        sig_in = 1'b0;
        repeat (per - per / 2 - per / 4 - 1) @(negedge clk);
    endtask

    task automatic apply_reset();
        sig_in = 1'b0;
        rst    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        bit do_rst;
        int per;
        int n;
        bit exp_present;
        int exp_period;
        int exp_pv;
        int exp_lost;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int pv0;
        int l0;
        bit got;
        int mode;
        int base;
        int n;
        int p;

        vecs[0]  = '{1'b1,  100, 5, 1'b1,  100, 1, 0};
        vecs[1]  = '{1'b0,  100, 3, 1'b1,  100, 3, 0};
        vecs[2]  = '{1'b1,  100, 1, 1'b0,    0, 0, 0};
        vecs[3]  = '{1'b0,  105, 1, 1'b0,    0, 0, 0};
        vecs[4]  = '{1'b0,   97, 1, 1'b0,    0, 0, 0};
        vecs[5]  = '{1'b0,  104, 1, 1'b0,    0, 0, 0};
        vecs[6]  = '{1'b0,   99, 1, 1'b1,  104, 1, 0};
        vecs[7]  = '{1'b0,  130, 1, 1'b1,   99, 1, 0};
        vecs[8]  = '{1'b0,  130, 1, 1'b0,   99, 0, 0};
        vecs[9]  = '{1'b0,  130, 2, 1'b0,   99, 0, 0};
        vecs[10] = '{1'b0,  130, 2, 1'b1,  130, 2, 0};
        vecs[11] = '{1'b1, 1000, 5, 1'b1, 1000, 1, 0};
        vecs[12] = '{1'b1, 1001, 4, 1'b0,    0, 0, 0};

        // Reset values.
        rst = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period", 64'(period), 64'(0));
        check("rst_valid", 64'(period_valid), 64'(0));
        check("rst_present", 64'(tone_present), 64'(0));
        check("rst_lost", 64'(lost), 64'(0));
        mon_en = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Scenario table: clean tone, jitter run, tolerance break, timeout boundary.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].do_rst) apply_reset();
            pv0 = pv_count;
            l0  = lost_count;
            repeat (vecs[i].n) tone_period(vecs[i].per, vecs[i].per / 2);
            check($sformatf("v%0d_present", i), 64'(tone_present), 64'(vecs[i].exp_present));
            check($sformatf("v%0d_period", i), 64'(period), 64'(vecs[i].exp_period));
            check($sformatf("v%0d_pulses", i), 64'(pv_count - pv0), 64'(vecs[i].exp_pv));
            check($sformatf("v%0d_lost", i), 64'(lost_count - l0), 64'(vecs[i].exp_lost));
        end

        // Timeout after lock: lost exactly TIMEOUT cycles after the last edge.
        apply_reset();
        repeat (6) tone_period(100, 50);
        l0  = lost_count;
        got = 1'b0;
        for (int i = 0; i < 1500 && !got; i++) begin
            @(negedge clk);
            if (lost_count != l0) got = 1'b1;
        end
        check("tmo_seen", 64'(got), 64'(1));
        check("tmo_delay", 64'(lost_edge - last_pv_edge), 64'(TB_TMO));
        @(negedge clk);
        check("tmo_lost_width", 64'(lost), 64'(0));
        check("tmo_present", 64'(tone_present), 64'(0));
        check("tmo_period_held", 64'(period), 64'(100));
        check("tmo_state", 64'(dut.r_state), 64'(IDLE));
        repeat (1100) @(negedge clk);
        check("tmo_lost_once", 64'(lost_count - l0), 64'(1));

        // One-cycle reset while locked, then a full relock.
        apply_reset();
        repeat (5) tone_period(100, 50);
        check("rl_locked", 64'(tone_present), 64'(1));
        sig_in = 1'b1;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rl_period", 64'(period), 64'(0));
        check("rl_valid", 64'(period_valid), 64'(0));
        check("rl_present", 64'(tone_present), 64'(0));
        check("rl_lost", 64'(lost), 64'(0));
        check("rl_state", 64'(dut.r_state), 64'(IDLE));
        sig_in = 1'b0;
        repeat (60) @(negedge clk);
        repeat (4) tone_period(100, 50);
        check("rl_four_rises", 64'(tone_present), 64'(0));
        tone_period(100, 50);
        check("rl_five_rises", 64'(tone_present), 64'(1));

        // Glitch mid-period: never a pulse with a corrupted period.
        apply_reset();
        repeat (6) tone_period(100, 50);
        glitch_phase = 1'b1;
        glitch_period(100);
        repeat (7) tone_period(100, 50);
        glitch_phase = 1'b0;
        check("glitch_bad_pulses", 64'(glitch_bad), 64'(0));
        check("glitch_relock", 64'(tone_present), 64'(1));

        // Random tones, jitter, gaps and glitches against the model.
        apply_reset();
        for (int s = 0; s < 30; s++) begin
            mode = int'($urandom_range(0, 9));
            base = int'($urandom_range(20, 150));
            n    = int'($urandom_range(1, 6));
            if (mode == 0) begin
                sig_in = 1'b0;
                repeat ($urandom_range(900, 1200)) @(negedge clk);
            end else if (mode == 1) begin
                glitch_period(base);
            end else begin
                for (int j = 0; j < n; j++) begin
                    p = base;
                    if (mode <= 4) p = base + int'($urandom_range(0, 2 * TOL + 4)) - int'(TOL + 2);
                    tone_period(p, p / 2);
                end
            end
        end
        sig_in = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
